// File: rtl/vector_mem_writer.sv
// vector_mem_writer: streams 24-bit float elements into consecutive memory words after a
// base address, then commits the length header at the base so readers never see a partial vector.
module vector_mem_writer #(
   parameter int word_size   = 24,
   parameter int len_size    = 8,
   parameter int memory_size = 512,
   parameter int addr_size   = 9,
   parameter int state_size  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [addr_size-1:0]  base_addr,
   input  logic [len_size-1:0]   len,
   input  logic [word_size-1:0]  in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [addr_size-1:0]  mem_addr,
   output logic [word_size-1:0]  mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic [len_size-1:0]   i,
   output logic [state_size-1:0] the_state
);
   typedef enum logic [state_size-1:0] {IDLE = 2'd0, DATA = 2'd1, HEADER = 2'd2, FIN = 2'd3} state_t;
   state_t state;
   logic [addr_size-1:0] base_q;
   logic [len_size-1:0]  len_q;
   assign in_ready  = state == DATA;
   assign busy      = state != IDLE;
   assign the_state = state;
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         done      <= 1'b0;
         i         <= '0;
         base_q    <= '0;
         len_q     <= '0;
      end else begin
         mem_we <= 1'b0;
         // done follows FIN by one cycle so it lands strictly after the header write is visible
         done   <= state == FIN;
         case (state)
            IDLE: if (start) begin
               base_q <= base_addr;
               len_q  <= len;
               i      <= '0;
               state  <= len != '0 ? DATA : HEADER;
            end
            DATA: if (in_valid) begin
               mem_we    <= 1'b1;
               mem_addr  <= base_q + addr_size'(i) + addr_size'(1);
               mem_wdata <= in_data;
               i         <= i + len_size'(1);
               if (i == len_q - len_size'(1)) state <= HEADER;
            end
            HEADER: begin
               mem_we    <= 1'b1;
               mem_addr  <= base_q;
               mem_wdata <= word_size'(len_q);
               state     <= FIN;
            end
            FIN: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vector_mem_writer.sv
// tb_vector_mem_writer: directed vectors against vector_mem_writer; every memory write is
// logged at the falling edge and compared with hand-computed addresses, data and latencies.
module tb_vector_mem_writer;
   logic        clk = 1'b0;
   logic        reset, start, in_valid;
   logic [8:0]  base_addr;
   logic [7:0]  len;
   logic [23:0] in_data;
   logic        in_ready, mem_we, busy, done;
   logic [8:0]  mem_addr;
   logic [23:0] mem_wdata;
   logic [7:0]  i;
   logic [1:0]  the_state;
   int checks = 0, errors = 0;
   int cyc = 0, st = 0, dn = 0, dcyc = 0;
   logic [7:0]  di;
   logic        rdy;
   logic [8:0]  wa[$];
   logic [23:0] wd[$];

   vector_mem_writer dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done), .i(i),
      .the_state(the_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (mem_we) begin
         wa.push_back(mem_addr);
         wd.push_back(mem_wdata);
      end
      if (done) begin
         dn++;
         dcyc = cyc;
         di = i;
      end
      if (in_ready) rdy = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_vec(input logic [8:0] b, input logic [7:0] l);
      wa.delete();
      wd.delete();
      dn = 0;
      rdy = 1'b0;
      base_addr = b;
      len = l;
      start = 1'b1;
      step();
      start = 1'b0;
      st = cyc;
   endtask

   task automatic send(input logic [23:0] d, input int stall);
      repeat (stall) step();
      in_valid = 1'b1;
      in_data = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic chk_write(input string tag, input int k, input logic [8:0] a, input logic [23:0] d);
      if (k < wa.size()) begin
         chk({tag, "_addr"}, 32'(wa[k]), 32'(a));
         chk({tag, "_data"}, 32'(wd[k]), 32'(d));
      end else chk({tag, "_missing"}, 32'(wa.size()), 32'(k + 1));
   endtask

   // latency counts the start cycle itself as cycle 1
   function automatic int lat();
      return dcyc - st + 1;
   endfunction

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; base_addr = '0; len = '0;
      rdy = 1'b0;
      repeat (2) step();
      chk("rst_state", 32'(the_state), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(in_ready), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_i", 32'(i), 0);
      reset = 1'b0;
      step();

      begin_vec(9'd49, 8'd2);
      chk("basic_state", 32'(the_state), 1);
      chk("basic_busy", 32'(busy), 1);
      chk("basic_ready", 32'(in_ready), 1);
      send(24'h03CBF8, 0);
      send(24'h037E80, 0);
      repeat (6) step();
      chk("basic_nwr", 32'(wa.size()), 3);
      chk_write("basic_w0", 0, 9'd50, 24'h03CBF8);
      chk_write("basic_w1", 1, 9'd51, 24'h037E80);
      chk_write("basic_hdr", 2, 9'd49, 24'h000002);
      chk("basic_ndone", dn, 1);
      chk("basic_lat", lat(), 5);
      chk("basic_i", 32'(di), 2);

      begin_vec(9'd0, 8'd3);
      send(24'h800000, 0);
      send(24'h000001, 2);
      send(24'h7F8000, 2);
      repeat (6) step();
      chk("stall_nwr", 32'(wa.size()), 4);
      chk_write("stall_w0", 0, 9'd1, 24'h800000);
      chk_write("stall_w1", 1, 9'd2, 24'h000001);
      chk_write("stall_w2", 2, 9'd3, 24'h7F8000);
      chk_write("stall_hdr", 3, 9'd0, 24'h000003);
      chk("stall_ndone", dn, 1);

      begin_vec(9'd10, 8'd0);
      in_valid = 1'b1;
      in_data = 24'hABCDEF;
      repeat (6) step();
      in_valid = 1'b0;
      chk("zero_nwr", 32'(wa.size()), 1);
      chk_write("zero_hdr", 0, 9'd10, 24'h000000);
      chk("zero_lat", lat(), 3);
      chk("zero_ready", 32'(rdy), 0);
      chk("zero_ndone", dn, 1);

      begin_vec(9'd510, 8'd3);
      send(24'h111111, 0);
      send(24'h222222, 0);
      send(24'h333333, 0);
      repeat (6) step();
      chk("wrap_nwr", 32'(wa.size()), 4);
      chk_write("wrap_w0", 0, 9'd511, 24'h111111);
      chk_write("wrap_w1", 1, 9'd0, 24'h222222);
      chk_write("wrap_w2", 2, 9'd1, 24'h333333);
      chk_write("wrap_hdr", 3, 9'd510, 24'h000003);

      begin_vec(9'd0, 8'd4);
      send(24'h0AAAAA, 0);
      send(24'h0BBBBB, 0);
      reset = 1'b1;
      step();
      chk("mid_state", 32'(the_state), 0);
      chk("mid_busy", 32'(busy), 0);
      chk("mid_we", 32'(mem_we), 0);
      chk("mid_i", 32'(i), 0);
      chk("mid_addr", 32'(mem_addr), 0);
      chk("mid_wdata", 32'(mem_wdata), 0);
      chk("mid_ready", 32'(in_ready), 0);
      reset = 1'b0;
      repeat (6) step();
      chk("mid_nwr", 32'(wa.size()), 2);
      chk_write("mid_w0", 0, 9'd1, 24'h0AAAAA);
      chk_write("mid_w1", 1, 9'd2, 24'h0BBBBB);
      chk("mid_ndone", dn, 0);
      begin_vec(9'd5, 8'd1);
      send(24'h0CCCCC, 0);
      repeat (6) step();
      chk("after_nwr", 32'(wa.size()), 2);
      chk_write("after_w0", 0, 9'd6, 24'h0CCCCC);
      chk_write("after_hdr", 1, 9'd5, 24'h000001);
      chk("after_ndone", dn, 1);

      begin_vec(9'd100, 8'd2);
      send(24'h0DDDDD, 0);
      base_addr = 9'd200;
      len = 8'd9;
      start = 1'b1;
      step();
      start = 1'b0;
      send(24'h0EEEEE, 0);
      repeat (6) step();
      chk("ign_nwr", 32'(wa.size()), 3);
      chk_write("ign_w0", 0, 9'd101, 24'h0DDDDD);
      chk_write("ign_w1", 1, 9'd102, 24'h0EEEEE);
      chk_write("ign_hdr", 2, 9'd100, 24'h000002);
      chk("ign_i", 32'(di), 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
